// File: rtl/wb_slave_router.sv
// Single-outstanding Wishbone router from the management port to the user and debug targets.
// Define WB_ROUTER_TIMEOUT_EN to terminate transactions whose target never acks.
module wb_slave_router #(
    parameter logic [31:0] USER_BASE      = 32'h3000_0000,
    parameter logic [31:0] DBG_ADDR       = 32'h30FF_FFF8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_C0DE
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tgt_we_o,
    output logic [3:0]  tgt_sel_o,
    output logic [31:0] tgt_adr_o,
    output logic [31:0] tgt_dat_o,
    output logic        user_cyc_o,
    output logic        user_stb_o,
    input  logic        user_ack_i,
    input  logic [31:0] user_dat_i,
    output logic        dbg_cyc_o,
    output logic        dbg_stb_o,
    input  logic        dbg_ack_i,
    input  logic [31:0] dbg_dat_i,
    input  logic        to_clr_i,
    output logic        to_flag_o,
    output logic [7:0]  to_cnt_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        sel_dbg;
    logic        user_act;
    logic        dbg_act;
    logic        req_start;
    logic        hit_dbg;
    logic        hit_user;
    logic        tgt_ack;
    logic [31:0] tgt_rdata;
    logic        timeout;
    logic        err_evt;

    assign user_cyc_o = user_act;
    assign user_stb_o = user_act;
    assign dbg_cyc_o  = dbg_act;
    assign dbg_stb_o  = dbg_act;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        req_start = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
        hit_dbg   = (wbs_adr_i[31:3] == DBG_ADDR[31:3]);
        hit_user  = !hit_dbg && (wbs_adr_i[31:24] == USER_BASE[31:24]);
        // Only the selected target's ack counts; the other one is ignored.
        tgt_ack   = sel_dbg ? dbg_ack_i : user_ack_i;
        tgt_rdata = sel_dbg ? dbg_dat_i : user_dat_i;
        err_evt   = (req_start && !hit_dbg && !hit_user) || timeout;
    end

`ifdef WB_ROUTER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timer;

    // Fires in the last permitted REQ cycle; an abort or a real ack takes priority.
    assign timeout = (state == REQ) && wbs_cyc_i && !tgt_ack && (timer == TO_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            timer <= 8'd0;
        end else if (state == REQ) begin
            timer <= timer + 8'd1;
        end else begin
            timer <= 8'd0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            sel_dbg   <= 1'b0;
            user_act  <= 1'b0;
            dbg_act   <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            tgt_we_o  <= 1'b0;
            tgt_sel_o <= 4'd0;
            tgt_adr_o <= 32'd0;
            tgt_dat_o <= 32'd0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
            case (state)
                IDLE: begin
                    if (req_start) begin
                        tgt_we_o  <= wbs_we_i;
                        tgt_sel_o <= wbs_sel_i;
                        tgt_adr_o <= wbs_adr_i;
                        tgt_dat_o <= wbs_dat_i;
                        sel_dbg   <= hit_dbg;
                        if (hit_dbg || hit_user) begin
                            state    <= REQ;
                            user_act <= hit_user;
                            dbg_act  <= hit_dbg;
                        end else begin
                            state     <= RESP;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= ERR_DATA;
                        end
                    end
                end
                REQ: begin
                    if (!wbs_cyc_i) begin
                        state    <= IDLE;
                        user_act <= 1'b0;
                        dbg_act  <= 1'b0;
                    end else if (tgt_ack || timeout) begin
                        state     <= RESP;
                        user_act  <= 1'b0;
                        dbg_act   <= 1'b0;
                        wbs_ack_o <= 1'b1;
                        if (!tgt_ack)      wbs_dat_o <= ERR_DATA;
                        else if (tgt_we_o) wbs_dat_o <= 32'd0;
                        else               wbs_dat_o <= tgt_rdata;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Clear has priority over a coincident error event.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            to_flag_o <= 1'b0;
            to_cnt_o  <= 8'd0;
        end else if (to_clr_i) begin
            to_flag_o <= 1'b0;
            to_cnt_o  <= 8'd0;
        end else if (err_evt) begin
            to_flag_o <= 1'b1;
            if (to_cnt_o != 8'hFF) to_cnt_o <= to_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_wb_slave_router.sv
// Directed bench for wb_slave_router: routing, latency, unmapped/timeout errors, abort, clear, reset.
// Build with WB_ROUTER_TIMEOUT_EN defined to also cover the watchdog path.
`timescale 1ns/1ps
module tb_wb_slave_router;

    localparam int unsigned TO_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        tgt_we;
    logic [3:0]  tgt_sel;
    logic [31:0] tgt_adr, tgt_dat;
    logic        user_cyc, user_stb, user_ack;
    logic [31:0] user_dat;
    logic        dbg_cyc, dbg_stb, dbg_ack;
    logic [31:0] dbg_dat;
    logic        to_clr, to_flag;
    logic [7:0]  to_cnt;

    int checks = 0;
    int errors = 0;

    wb_slave_router #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .tgt_we_o   (tgt_we),
        .tgt_sel_o  (tgt_sel),
        .tgt_adr_o  (tgt_adr),
        .tgt_dat_o  (tgt_dat),
        .user_cyc_o (user_cyc),
        .user_stb_o (user_stb),
        .user_ack_i (user_ack),
        .user_dat_i (user_dat),
        .dbg_cyc_o  (dbg_cyc),
        .dbg_stb_o  (dbg_stb),
        .dbg_ack_i  (dbg_ack),
        .dbg_dat_i  (dbg_dat),
        .to_clr_i   (to_clr),
        .to_flag_o  (to_flag),
        .to_cnt_o   (to_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = a; wdat = d;
    endtask

    task automatic end_req();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    int lat;

    initial begin
        rst_n = 1'b0;
        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        user_ack = 0; user_dat = 0; dbg_ack = 0; dbg_dat = 0; to_clr = 0;
        #12;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_user_cyc", 32'(user_cyc), 32'd0);
        check("rst_cnt", 32'(to_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // User read, ack in first stb cycle: request N, stb N+1, wbs ack N+2.
        drive_req(1'b0, 32'h3000_0010, 32'd0);
        check("u_idle_cyc", 32'(user_cyc), 32'd0);
        step();
        check("u_cyc", 32'(user_cyc), 32'd1);
        check("u_stb", 32'(user_stb), 32'd1);
        check("u_dbg_off", 32'(dbg_cyc), 32'd0);
        check("u_adr", tgt_adr, 32'h3000_0010);
        user_ack = 1'b1; user_dat = 32'h1234_5678;
        step();
        user_ack = 1'b0;
        check("u_ack", 32'(ack), 32'd1);
        check("u_dat", rdat, 32'h1234_5678);
        check("u_cyc_resp", 32'(user_cyc), 32'd0);
        check("u_dbg_off2", 32'(dbg_cyc), 32'd0);
        end_req();
        step();
        check("u_ack_pulse", 32'(ack), 32'd0);
        check("u_dat_zero", rdat, 32'd0);

        // Debug write; a stray user ack in REQ must be ignored; write returns 0 data.
        drive_req(1'b1, 32'h30FF_FFFC, 32'hA5A5_A5A5);
        step();
        check("d_stb", 32'(dbg_stb), 32'd1);
        check("d_user_off", 32'(user_cyc), 32'd0);
        check("d_wdat", tgt_dat, 32'hA5A5_A5A5);
        check("d_sel", 32'(tgt_sel), 32'hF);
        check("d_we", 32'(tgt_we), 32'd1);
        user_ack = 1'b1;
        step();
        user_ack = 1'b0;
        check("d_stray_ack", 32'(ack), 32'd0);
        check("d_stb_hold", 32'(dbg_stb), 32'd1);
        dbg_ack = 1'b1; dbg_dat = 32'hFFFF_FFFF;
        step();
        dbg_ack = 1'b0;
        check("d_ack", 32'(ack), 32'd1);
        check("d_wr_dat", rdat, 32'd0);
        end_req();
        step();

        // Unmapped read: ack in N+1 with error data, one error counted.
        drive_req(1'b0, 32'h2000_0000, 32'd0);
        step();
        check("x_ack", 32'(ack), 32'd1);
        check("x_dat", rdat, 32'hDEAD_C0DE);
        check("x_cnt", 32'(to_cnt), 32'd1);
        check("x_flag", 32'(to_flag), 32'd1);
        check("x_no_tgt", 32'(user_cyc | dbg_cyc), 32'd0);
        end_req();
        step();

`ifdef WB_ROUTER_TIMEOUT_EN
        // Silent user target: TO_CYC REQ cycles, ack in N+TO_CYC+1 with error data.
        drive_req(1'b0, 32'h3000_0100, 32'd0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (ack) begin
                lat = i;
                break;
            end
        end
        check("to_latency", 32'(lat), 32'(TO_CYC + 1));
        check("to_dat", rdat, 32'hDEAD_C0DE);
        check("to_cnt", 32'(to_cnt), 32'd2);
        check("to_user_off", 32'(user_cyc), 32'd0);
        end_req();
        user_ack = 1'b1; user_dat = 32'h5555_5555;
        step();
        check("to_late_ack", 32'(ack), 32'd0);
        user_ack = 1'b0;
        step();
        check("to_late_ack2", 32'(ack), 32'd0);
`endif

        // Abort: cyc dropped 2 cycles into REQ; strobes fall next cycle, no ack.
        drive_req(1'b0, 32'h3000_0020, 32'd0);
        step();
`ifndef WB_ROUTER_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack) check("wait_no_ack", 32'(ack), 32'd0);
        end
        check("wait_stb_held", 32'(user_stb), 32'd1);
`endif
        step();
        end_req();
        check("ab_stb_still", 32'(user_cyc), 32'd1);
        step();
        check("ab_cyc_low", 32'(user_cyc), 32'd0);
        check("ab_no_ack", 32'(ack), 32'd0);
        step();
        check("ab_no_ack2", 32'(ack), 32'd0);

        // Next transaction after abort completes normally.
        drive_req(1'b0, 32'h30FF_FFF8, 32'd0);
        step();
        check("nx_dbg_cyc", 32'(dbg_cyc), 32'd1);
        dbg_ack = 1'b1; dbg_dat = 32'hCAFE_F00D;
        step();
        dbg_ack = 1'b0;
        check("nx_ack", 32'(ack), 32'd1);
        check("nx_dat", rdat, 32'hCAFE_F00D);
        end_req();
        step();

        // Clear coincident with an unmapped access: clear wins.
        drive_req(1'b0, 32'h0000_0004, 32'd0);
        to_clr = 1'b1;
        step();
        to_clr = 1'b0;
        check("clr_ack", 32'(ack), 32'd1);
        check("clr_cnt", 32'(to_cnt), 32'd0);
        check("clr_flag", 32'(to_flag), 32'd0);
        end_req();
        step();
        check("clr_cnt_after", 32'(to_cnt), 32'd0);

        // Counter saturates at 255 after 260 unmapped accesses.
        for (int i = 0; i < 260; i++) begin
            drive_req(1'b0, 32'h4000_0000, 32'd0);
            step();
            end_req();
            step();
        end
        check("sat_cnt", 32'(to_cnt), 32'd255);
        check("sat_flag", 32'(to_flag), 32'd1);

        // Reset asserted mid-REQ between edges clears every output immediately.
        drive_req(1'b1, 32'h3000_0040, 32'h0BAD_F00D);
        step();
        check("rr_cyc_before", 32'(user_cyc), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_user_cyc", 32'(user_cyc), 32'd0);
        check("rr_ack", 32'(ack), 32'd0);
        check("rr_adr", tgt_adr, 32'd0);
        check("rr_dat", tgt_dat, 32'd0);
        check("rr_cnt", 32'(to_cnt), 32'd0);
        check("rr_flag", 32'(to_flag), 32'd0);
        end_req();
        step();
        rst_n = 1'b1;
        step();
        check("rr_no_ack", 32'(ack), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
